// File: rtl/serial_adder_pkg.sv
// Shared constants and state encoding for the bit-serial adder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package serial_adder_pkg;

  // Default operand and sum width
  localparam int DEFAULT_WIDTH = 8;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full adder assembled from two-input gate primitives.
// Latency: purely combinational.
// Backpressure: none; the outputs follow the inputs.

// Two-input XOR primitive
module serial_adder_xor2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

// Two-input AND primitive
module serial_adder_and2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

// Two-input OR primitive
module serial_adder_or2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a | b;
endmodule

// s = a ^ b ^ ci ; co = (a & b) | (ci & (a ^ b))
module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic half_sum;   // a ^ b, shared by the sum and the propagate term
  logic gen;        // a & b
  logic prop;       // ci & (a ^ b)

  serial_adder_xor2 u_xor_ab  (.a(a),        .b(b),    .y(half_sum));
  serial_adder_xor2 u_xor_sum (.a(half_sum), .b(ci),   .y(s));
  serial_adder_and2 u_and_gen (.a(a),        .b(b),    .y(gen));
  serial_adder_and2 u_and_prp (.a(ci),       .b(half_sum), .y(prop));
  serial_adder_or2  u_or_co   (.a(gen),      .b(prop), .y(co));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit pair per clock through a single full adder.
// Latency: done pulses in the cycle after the WIDTH-th edge following the accept edge.
// Backpressure: start is only honoured in IDLE; requests in RUN/DONE are dropped.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  // A one-bit datapath cannot hold the accumulator slice used below
  if (WIDTH < 2) begin : g_bad_width
    $error("serial_adder: WIDTH must be at least 2");
  end

  state_t           state;
  logic [WIDTH-1:0] a_sh;     // operand A, LSB is the bit in flight
  logic [WIDTH-1:0] b_sh;     // operand B, LSB is the bit in flight
  logic [WIDTH-1:0] acc;      // partial sum, filled from the MSB downward
  logic             carry;    // carry between consecutive bit positions
  logic [CW-1:0]    cnt;      // index of the bit being processed

  logic             fa_s;
  logic             fa_co;

  // The single shared full adder sees the current bit pair and the stored carry
  serial_adder_fa u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Controller, datapath and registered outputs in one sequential block
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end

        ST_RUN: begin
          // After WIDTH shifts bit 0 of the result has reached acc[0]
          acc   <= {fa_s, acc[WIDTH-1:1]};
          carry <= fa_co;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            // Publish the result including the bit produced on this edge
            sum   <= {fa_s, acc[WIDTH-1:1]};
            cout  <= fa_co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          // Single-cycle pulse; start is not looked at here
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at widths 4, 8 and 16.
// Latency: expected timing comes from the accept-edge model of the block.
// Backpressure: start is toggled during RUN/DONE and must be ignored.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  start_v;
  logic [15:0] a_i, b_i;
  logic        cin_i;

  logic        busy4, done4, cout4;
  logic [3:0]  sum4;
  logic        busy8, done8, cout8;
  logic [7:0]  sum8;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;

  int tests = 0;
  int fails = 0;

  int          cur = 0;
  logic        busy_m, done_m, cout_m;
  logic [15:0] sum_m;
  logic [15:0] prev_sum [3];
  logic        prev_cout [3];

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start_v[0]), .a(a_i[3:0]), .b(b_i[3:0]),
    .cin(cin_i), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4));

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start_v[1]), .a(a_i[7:0]), .b(b_i[7:0]),
    .cin(cin_i), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start_v[2]), .a(a_i), .b(b_i),
    .cin(cin_i), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16));

  // Observe the instance currently under test
  always_comb begin
    busy_m = busy8;
    done_m = done8;
    cout_m = cout8;
    sum_m  = {8'h00, sum8};
    case (cur)
      0: begin busy_m = busy4;  done_m = done4;  cout_m = cout4;  sum_m = {12'h000, sum4}; end
      2: begin busy_m = busy16; done_m = done16; cout_m = cout16; sum_m = sum16; end
      default: ;
    endcase
  end

  function automatic int width_of(input int sel);
    return (sel == 0) ? 4 : (sel == 1) ? 8 : 16;
  endfunction

  function automatic logic [15:0] mask_of(input int sel);
    return (sel == 0) ? 16'h000F : (sel == 1) ? 16'h00FF : 16'hFFFF;
  endfunction

  // Reference: plain (WIDTH+1)-bit arithmetic a + b + cin
  function automatic logic [16:0] ref_add(input int sel, input logic [15:0] a,
                                          input logic [15:0] b, input logic c);
    logic [16:0] m;
    m = {1'b0, mask_of(sel)};
    return ({1'b0, a} & m) + ({1'b0, b} & m) + {16'h0000, c};
  endfunction

  // One full operation from IDLE back to IDLE with per-cycle checks
  task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input bit noise);
    int          w;
    logic [16:0] r;
    logic [15:0] exp_sum;
    logic        exp_cout;
    w        = width_of(sel);
    r        = ref_add(sel, a, b, c);
    exp_sum  = r[15:0] & mask_of(sel);
    exp_cout = r[w];
    cur      = sel;
    start_v[sel] = 1'b1;
    a_i = a; b_i = b; cin_i = c;
    @(posedge clk); #1;
    for (int i = 0; i < w; i++) begin
      if (noise) begin
        start_v[sel] = 1'($urandom_range(0, 1));
        a_i = 16'($urandom); b_i = 16'($urandom); cin_i = 1'($urandom_range(0, 1));
      end else begin
        start_v[sel] = 1'b0;
      end
      @(negedge clk);
      tests++;
      if (busy_m !== 1'b1 || done_m !== 1'b0) begin
        fails++;
        $display("FAIL run_flags w=%0d bit=%0d got busy=%b done=%b want busy=1 done=0", w, i, busy_m, done_m);
      end
      tests++;
      if (sum_m !== prev_sum[sel] || cout_m !== prev_cout[sel]) begin
        fails++;
        $display("FAIL result_hold w=%0d bit=%0d got %b/%h want %b/%h", w, i, cout_m, sum_m, prev_cout[sel], prev_sum[sel]);
      end
      @(posedge clk); #1;
    end
    // Now in DONE; a start here must be ignored
    start_v[sel] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
    tests++;
    if (done_m !== 1'b1 || busy_m !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse w=%0d got busy=%b done=%b want busy=0 done=1", w, busy_m, done_m);
    end
    tests++;
    if (sum_m !== exp_sum || cout_m !== exp_cout) begin
      fails++;
      $display("FAIL result w=%0d a=%h b=%h cin=%b got %b/%h want %b/%h", w, a, b, c, cout_m, sum_m, exp_cout, exp_sum);
    end
    prev_sum[sel]  = exp_sum;
    prev_cout[sel] = exp_cout;
    @(posedge clk); #1;
    start_v[sel] = 1'b0;
    @(negedge clk);
    tests++;
    if (done_m !== 1'b0 || busy_m !== 1'b0) begin
      fails++;
      $display("FAIL after_done w=%0d got busy=%b done=%b want busy=0 done=0", w, busy_m, done_m);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start_v = 3'b111; a_i = 16'hFFFF; b_i = 16'hFFFF; cin_i = 1'b1;
    repeat (3) @(posedge clk);
    #1; start_v = 3'b000;
    for (int s = 0; s < 3; s++) begin
      cur = s; #1;
      tests++;
      if (busy_m !== 1'b0 || done_m !== 1'b0 || sum_m !== 16'h0 || cout_m !== 1'b0) begin
        fails++;
        $display("FAIL reset_state sel=%0d got busy=%b done=%b cout=%b sum=%h want all zero", s, busy_m, done_m, cout_m, sum_m);
      end
      prev_sum[s] = 16'h0; prev_cout[s] = 1'b0;
    end
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    run_op(1, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    run_op(0, 16'h0009, 16'h0007, 1'b0, 1'b0);
    run_op(2, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_op(1, 16'h005A, 16'h00A5, 1'b1, 1'b0);
    run_op(1, 16'h0012, 16'h0034, 1'b0, 1'b0);
  endtask

  // start held high: accepts at edges 0, 10, 20 of a WIDTH=8 block
  task automatic test_throughput();
    int  ndone;
    bit  exp_busy, exp_done;
    ndone = 0;
    cur = 1;
    a_i = 16'h0003; b_i = 16'h0004; cin_i = 1'b0;
    start_v[1] = 1'b1;
    for (int e = 0; e < 42; e++) begin
      @(posedge clk); #1;
      if (e == 29) start_v[1] = 1'b0;
      @(negedge clk);
      exp_busy = (e < 28) && ((e % 10) <= 7);
      exp_done = (e <= 28) && ((e % 10) == 8);
      tests++;
      if (busy_m !== exp_busy || done_m !== exp_done) begin
        fails++;
        $display("FAIL throughput_timing edge=%0d got busy=%b done=%b want busy=%b done=%b", e, busy_m, done_m, exp_busy, exp_done);
      end
      if (done_m === 1'b1) begin
        ndone++;
        tests++;
        if (sum_m !== 16'h0007 || cout_m !== 1'b0) begin
          fails++;
          $display("FAIL throughput_sum edge=%0d got %b/%h want 0/0007", e, cout_m, sum_m);
        end
      end
    end
    tests++;
    if (ndone != 3) begin
      fails++;
      $display("FAIL throughput_count got %0d done pulses want 3", ndone);
    end
    prev_sum[1] = 16'h0007; prev_cout[1] = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bit saw_done;
    saw_done = 1'b0;
    cur = 1;
    start_v[1] = 1'b1; a_i = 16'h00F0; b_i = 16'h000F; cin_i = 1'b0;
    @(posedge clk); #1; start_v[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (busy_m !== 1'b0 || done_m !== 1'b0 || sum_m !== 16'h0 || cout_m !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_run got busy=%b done=%b cout=%b sum=%h want all zero", busy_m, done_m, cout_m, sum_m);
    end
    #4; reset = 1'b0;
    for (int s = 0; s < 3; s++) begin prev_sum[s] = 16'h0; prev_cout[s] = 1'b0; end
    repeat (12) begin
      @(negedge clk);
      if (done_m === 1'b1 || busy_m === 1'b1) saw_done = 1'b1;
    end
    tests++;
    if (saw_done) begin
      fails++;
      $display("FAIL reset_no_done got activity after reset want idle");
    end
    run_op(1, 16'h00F0, 16'h000F, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int s = 0; s < 3; s++) begin
      for (int n = 0; n < 1000; n++) begin
        run_op(s, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start_v = 3'b000; a_i = 16'h0; b_i = 16'h0; cin_i = 1'b0;
    test_reset();
    test_wrap();
    test_back_to_back();
    test_throughput();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
